hb_interp: RTL and testbench

//  Halfband interpolate-by-2 stage for the DUC chain; transmit-side counterpart of the DDC final halfband decimator.

---
 rtl/hb_interp_if.sv | 24 ++
 rtl/hb_interp.sv | 202 ++++++++++++++++++++
 tb/tb_hb_interp.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hb_interp_if.sv
// Sample-stream bundle for the halfband interpolator: control, input strobe/data, output strobe/data, overrun flag.
// Every strobe is a single-cycle pulse; data is qualified only while its strobe is high and there is no back-pressure.
interface hb_interp_if #(
    parameter int WIDTH = 16
);
    logic             bypass;
    logic             run;
    logic [8:0]       cpo;
    logic             stb_in;
    logic [WIDTH-1:0] data_in;
    logic             stb_out;
    logic [WIDTH-1:0] data_out;
    logic             ovf;

    modport master (
        output bypass, run, cpo, stb_in, data_in,
        input  stb_out, data_out, ovf
    );

    modport slave (
        input  bypass, run, cpo, stb_in, data_in,
        output stb_out, data_out, ovf
    );
endinterface

// File: rtl/hb_interp.sv
// Halfband interpolate-by-2: each accepted sample yields a filtered output F then, cpo clocks later, the centre tap C.
// 16-deep delay line, symmetric pre-adds, two multipliers, four accumulate phases, fixed 10-clock F latency.
module hb_interp #(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       rst,
    hb_interp_if.slave bus
);
    localparam int PIPE = 6;
    localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [37:0] SAT_MAX = (38'sd1 <<< (WIDTH-1)) - 38'sd1;
    localparam logic signed [37:0] SAT_MIN = -(38'sd1 <<< (WIDTH-1));

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_1    = 3'd1,
        PH_2    = 3'd2,
        PH_3    = 3'd3,
        PH_4    = 3'd4
    } phase_e;

    function automatic logic signed [17:0] coef(input logic [2:0] idx);
        logic signed [17:0] c;
        case (idx)
            3'd0:    c = -18'sd107;
            3'd1:    c = 18'sd445;
            3'd2:    c = -18'sd1271;
            3'd3:    c = 18'sd2959;
            3'd4:    c = -18'sd6107;
            3'd5:    c = 18'sd11953;
            3'd6:    c = -18'sd24706;
            default: c = 18'sd82359;
        endcase
        return c;
    endfunction

    function automatic logic signed [17:0] sx(input logic signed [WIDTH-1:0] v);
        return {{(18-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    logic signed [WIDTH-1:0] dly_q [16];
    phase_e                  phase_q;
    logic signed [37:0]      acc_q;
    logic signed [WIDTH-1:0] ctr_hold_q;
    logic [PIPE-1:0]         pv_q;
    logic signed [WIDTH-1:0] pf_q [PIPE];
    logic signed [WIDTH-1:0] pc_q [PIPE];
    logic                    c_pend_q;
    logic [8:0]              c_cnt_q;
    logic signed [WIDTH-1:0] c_val_q;
    logic                    stb_out_q;
    logic [WIDTH-1:0]        data_out_q;
    logic                    ovf_q;

    logic [1:0]              k_d;
    logic [3:0]              ia_d, ib_d, ic_d, id_d;
    logic signed [17:0]      pre_a_d, pre_b_d;
    logic signed [35:0]      prod_a_d, prod_b_d;
    logic signed [37:0]      acc_base_d, acc_sum_d, rnd_d, shifted_d;
    logic signed [WIDTH-1:0] f_sat_d;
    logic                    slot_free_d, accept_d, drop_d;
    logic                    f_emit_d, c_emit_d, overrun_d;

    // Phase k (1..4) folds in tap pairs k-1 and k+3 from the already-written delay line.
    always_comb begin
        k_d = 2'd0;
        case (phase_q)
            PH_2:    k_d = 2'd1;
            PH_3:    k_d = 2'd2;
            PH_4:    k_d = 2'd3;
            default: k_d = 2'd0;
        endcase
        ia_d = {2'b00, k_d};
        ib_d = 4'd15 - ia_d;
        ic_d = ia_d + 4'd4;
        id_d = 4'd11 - ia_d;

        pre_a_d  = sx(dly_q[ia_d]) + sx(dly_q[ib_d]);
        pre_b_d  = sx(dly_q[ic_d]) + sx(dly_q[id_d]);
        prod_a_d = pre_a_d * coef({1'b0, k_d});
        prod_b_d = pre_b_d * coef({1'b1, k_d});

        acc_base_d = (phase_q == PH_1) ? 38'sd0 : acc_q;
        acc_sum_d  = acc_base_d + $signed({{2{prod_a_d[35]}}, prod_a_d})
                                + $signed({{2{prod_b_d[35]}}, prod_b_d});
        rnd_d      = acc_sum_d + 38'sd65536;
        shifted_d  = rnd_d >>> 17;

        if (shifted_d > SAT_MAX) begin
            f_sat_d = MAX_W;
        end else if (shifted_d < SAT_MIN) begin
            f_sat_d = MIN_W;
        end else begin
            f_sat_d = shifted_d[WIDTH-1:0];
        end
    end

    // The final accumulate phase reads the old delay line on the same edge a new write lands,
    // so a fresh sample may already be accepted while PH_4 completes.
    always_comb begin
        slot_free_d = (phase_q == PH_IDLE) || (phase_q == PH_4);
        accept_d    = !bus.bypass && bus.run && bus.stb_in && slot_free_d;
        drop_d      = !bus.bypass && bus.run && bus.stb_in && !slot_free_d;
        f_emit_d    = bus.run && pv_q[PIPE-1];
        c_emit_d    = bus.run && c_pend_q && (c_cnt_q == 9'd1);
        overrun_d   = f_emit_d && c_pend_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) dly_q[i] <= '0;
            phase_q    <= PH_IDLE;
            acc_q      <= '0;
            ctr_hold_q <= '0;
            pv_q       <= '0;
            for (int i = 0; i < PIPE; i++) begin
                pf_q[i] <= '0;
                pc_q[i] <= '0;
            end
            c_pend_q   <= 1'b0;
            c_cnt_q    <= '0;
            c_val_q    <= '0;
            stb_out_q  <= 1'b0;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (accept_d) begin
                for (int i = 15; i > 0; i--) dly_q[i] <= dly_q[i-1];
                dly_q[0]   <= $signed(bus.data_in);
                ctr_hold_q <= dly_q[6];
            end

            if (!bus.run) begin
                phase_q <= PH_IDLE;
            end else if (accept_d) begin
                phase_q <= PH_1;
            end else begin
                case (phase_q)
                    PH_1:    phase_q <= PH_2;
                    PH_2:    phase_q <= PH_3;
                    PH_3:    phase_q <= PH_4;
                    default: phase_q <= PH_IDLE;
                endcase
            end

            if (phase_q == PH_1 || phase_q == PH_2 || phase_q == PH_3) begin
                acc_q <= acc_sum_d;
            end

            // Fixed-latency result pipe: several results can be in flight at the minimum input spacing.
            if (!bus.run) begin
                pv_q <= '0;
            end else begin
                pv_q <= {pv_q[PIPE-2:0], (phase_q == PH_4)};
            end
            for (int i = PIPE-1; i > 0; i--) begin
                pf_q[i] <= pf_q[i-1];
                pc_q[i] <= pc_q[i-1];
            end
            pf_q[0] <= f_sat_d;
            pc_q[0] <= ctr_hold_q;

            if (!bus.run) begin
                c_pend_q <= 1'b0;
                c_cnt_q  <= '0;
            end else if (f_emit_d) begin
                c_pend_q <= 1'b1;
                c_cnt_q  <= bus.cpo;
                c_val_q  <= pc_q[PIPE-1];
            end else if (c_pend_q) begin
                if (c_cnt_q == 9'd1) begin
                    c_pend_q <= 1'b0;
                end
                c_cnt_q <= c_cnt_q - 9'd1;
            end

            if (drop_d || overrun_d) begin
                ovf_q <= 1'b1;
            end

            if (bus.bypass) begin
                stb_out_q <= bus.stb_in;
                if (bus.stb_in) begin
                    data_out_q <= bus.data_in;
                end
            end else begin
                stb_out_q <= f_emit_d || c_emit_d;
                if (f_emit_d) begin
                    data_out_q <= pf_q[PIPE-1];
                end else if (c_emit_d) begin
                    data_out_q <= c_val_q;
                end
            end
        end
    end

    assign bus.stb_out  = stb_out_q;
    assign bus.data_out = data_out_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_hb_interp.sv
// Bench for hb_interp: directed sample streams, a reference sum for F, and a timed expected queue of output samples.
module tb_hb_interp;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hb_interp_if #(.WIDTH(W)) bus();
    hb_interp #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    string        exp_tag_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           chk_en = 1'b1;
    longint       hist[16];
    longint       cf[8] = '{-107, 445, -1271, 2959, -6107, 11953, -24706, 82359};

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint model_f();
        longint acc = 0;
        longint r;
        for (int k = 0; k < 8; k++) acc += cf[k] * (hist[k] + hist[15-k]);
        r = (acc + 65536) >>> 17;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic push(input longint d, input int c, input string t);
        exp_q.push_back(W'(d));
        exp_cyc_q.push_back(c);
        exp_tag_q.push_back(t);
    endtask

    // Monitor: every output strobe must match the head of the queue in value and cycle.
    always @(negedge clk) begin
        if (!rst && chk_en && bus.stb_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                logic [W-1:0] e;
                int ec;
                string t;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                t  = exp_tag_q.pop_front();
                check({"data_", t}, longint'($signed(bus.data_out)), longint'($signed(e)));
                check({"time_", t}, cyc, ec);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input longint d, output int ac);
        @(negedge clk);
        bus.stb_in  = 1'b1;
        bus.data_in = W'(d);
        ac = cyc + 1;
        @(negedge clk);
        bus.stb_in  = 1'b0;
    endtask

    task automatic shift_hist(input longint d);
        for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
    endtask

    task automatic feed(input longint d, input int gap, input bit f_fix, input longint f_val, input bit want_c);
        int ac;
        send(d, ac);
        shift_hist(d);
        push(f_fix ? f_val : model_f(), ac + 10, "F");
        if (want_c) push(hist[7], ac + 10 + int'(bus.cpo), "C");
        idle(gap - 2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.stb_in = 1'b0;
        @(negedge clk);
        check("rst_stb_out", bus.stb_out, 0);
        check("rst_data_out", longint'(bus.data_out), 0);
        check("rst_ovf", bus.ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) hist[i] = 0;
        exp_q.delete();
        exp_cyc_q.delete();
        exp_tag_q.delete();
    endtask

    task automatic drain(input string name);
        idle(30);
        check({"drain_", name}, exp_q.size(), 0);
        exp_q.delete();
        exp_cyc_q.delete();
        exp_tag_q.delete();
    endtask

    initial begin
        longint f_tab[16] = '{-1, 3, -10, 23, -47, 91, -188, 628, 628, -188, 91, -47, 23, -10, 3, -1};
        longint sg[16]    = '{-1, 1, -1, 1, -1, 1, -1, 1, 1, -1, 1, -1, 1, -1, 1, -1};
        longint vals[8]   = '{5000, -7000, 3000, -1500, 12000, 800, -9000, 2500};
        longint byp[3]    = '{longint'(16'h1234), longint'(16'h0abc), longint'(16'h7f01)};
        int ac;
        int last_ac;

        rst = 1'b1;
        bus.bypass  = 1'b0;
        bus.run     = 1'b1;
        bus.cpo     = 9'd4;
        bus.stb_in  = 1'b0;
        bus.data_in = '0;
        do_reset();

        // Impulse response, hand-tabulated
        for (int n = 0; n < 16; n++) begin
            send(n == 0 ? 1000 : 0, ac);
            shift_hist(n == 0 ? 1000 : 0);
            push(f_tab[n], ac + 10, "F_imp");
            push(n == 7 ? 1000 : 0, ac + 14, "C_imp");
            idle(6);
        end
        drain("impulse");
        check("impulse_ovf", bus.ovf, 0);

        // DC settles at 19997 once the line is full
        do_reset();
        for (int n = 0; n < 40; n++) feed(20000, 8, n >= 15, 19997, 1'b1);
        drain("dc");
        check("dc_ovf", bus.ovf, 0);

        // Saturation in both directions
        do_reset();
        for (int n = 0; n < 16; n++) feed(sg[n] * 32767, 8, n == 15, 32767, 1'b1);
        for (int n = 0; n < 16; n++) feed(-sg[n] * 32767, 8, n == 15, -32768, 1'b1);
        drain("clip");

        // Rate violation: 3-clock spacing drops every other sample
        do_reset();
        chk_en  = 1'b0;
        last_ac = -100;
        for (int n = 0; n < 8; n++) begin
            send(vals[n], ac);
            if (ac - last_ac >= 4) begin
                shift_hist(vals[n]);
                last_ac = ac;
            end
            idle(1);
        end
        idle(40);
        check("rate_ovf_set", bus.ovf, 1);
        chk_en = 1'b1;
        for (int n = 0; n < 15; n++) feed(0, 8, 1'b0, 0, 1'b1);
        drain("rate_history");
        do_reset();
        for (int n = 0; n < 6; n++) feed(vals[n], 8, 1'b0, 0, 1'b1);
        drain("rate_legal");
        check("rate_ovf_clear", bus.ovf, 0);

        // Bypass: one strobe per input, the next clock
        do_reset();
        bus.bypass = 1'b1;
        for (int n = 0; n < 3; n++) begin
            send(byp[n], ac);
            push(byp[n], ac, "BYP");
            idle(2);
        end
        idle(3);
        check("byp_hold", longint'(bus.data_out), byp[2]);
        bus.bypass = 1'b0;
        drain("bypass");

        // run=0 between F and C kills C; delay line survives
        do_reset();
        bus.cpo = 9'd6;
        feed(12345, 2, 1'b0, 0, 1'b0);
        idle(12);
        bus.run = 1'b0;
        idle(2);
        bus.run = 1'b1;
        idle(10);
        feed(-4000, 12, 1'b0, 0, 1'b1);
        feed(7000, 12, 1'b0, 0, 1'b1);
        feed(100, 12, 1'b0, 0, 1'b1);
        drain("run_gap");

        // rst between F and C kills C and clears the line
        feed(-22222, 2, 1'b0, 0, 1'b0);
        idle(12);
        do_reset();
        idle(10);
        feed(3000, 12, 1'b0, 0, 1'b1);
        feed(-3000, 12, 1'b0, 0, 1'b1);
        feed(25000, 12, 1'b0, 0, 1'b1);
        drain("rst_gap");
        check("final_ovf", bus.ovf, 0);

        check("final_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
